accum_alu: RTL and testbench

//  Parametrised, registered unsigned add/subtract/accumulate unit; next generation of the

---
 rtl/accum_alu.sv | 81 ++++++++
 tb/tb_accum_alu.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/accum_alu.sv
// Registered unsigned add/subtract/accumulate unit with optional saturation,
// sticky overflow, an accumulate counter and valid/enable qualification.
module accum_alu #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             carry,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] acc_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             accept;
  logic             is_acc;
  logic             is_sub;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   sum;
  logic             cy;
  logic [WIDTH-1:0] res_n;
  logic [CNT_W-1:0] cnt_n;

  assign accept = ena & in_valid & ~acc_clr;
  assign is_acc = op[1];
  assign is_sub = op[0];

  // ACC/DEC reuse the registered result as the left operand, a as the right.
  assign lhs = is_acc ? result : a;
  assign rhs = is_acc ? a : b;

  always_comb begin
    sum   = '0;
    res_n = '0;
    cnt_n = '0;
    if (is_sub) sum = {1'b0, lhs} - {1'b0, rhs};
    else        sum = {1'b0, lhs} + {1'b0, rhs};
    cy = sum[WIDTH];
    // A borrow clamps to zero, a carry to all ones; the flag stays raw either way.
    if (SATURATE && cy) res_n = is_sub ? '0 : {WIDTH{1'b1}};
    else                res_n = sum[WIDTH-1:0];
    if (is_acc) cnt_n = (acc_count == CNT_MAX) ? acc_count : acc_count + 1'b1;
    else        cnt_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      out_valid  <= 1'b0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
      acc_count  <= '0;
    end else begin
      // out_valid is a pulse: it drops on every non-accept edge, even with ena low.
      out_valid <= accept;
      if (ena && acc_clr) begin
        result     <= '0;
        carry      <= 1'b0;
        ovf_sticky <= 1'b0;
        acc_count  <= '0;
      end else if (accept) begin
        result     <= res_n;
        carry      <= cy;
        ovf_sticky <= ovf_sticky | cy;
        acc_count  <= cnt_n;
      end
    end
  end

endmodule

// File: tb/tb_accum_alu.sv
// Directed bench: a saturating and a wrapping accum_alu share one stimulus stream.
module tb_accum_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       acc_clr;

  logic [7:0] res_s, res_w;
  logic       vld_s, vld_w, cy_s, cy_w, ovf_s, ovf_w;
  logic [3:0] cnt_s, cnt_w;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, DEC = 2'b11;

  always #5 clk = ~clk;

  accum_alu #(.WIDTH(8), .SATURATE(1'b1), .CNT_W(4)) d_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .acc_clr(acc_clr), .result(res_s), .out_valid(vld_s), .carry(cy_s),
    .ovf_sticky(ovf_s), .acc_count(cnt_s));

  accum_alu #(.WIDTH(8), .SATURATE(1'b0), .CNT_W(4)) d_w (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .acc_clr(acc_clr), .result(res_w), .out_valid(vld_w), .carry(cy_w),
    .ovf_sticky(ovf_w), .acc_count(cnt_w));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances (s = saturating, w = wrapping).
  task automatic expect_out(input string tag,
                            input logic [7:0] rs, input logic [7:0] rw, input logic vld,
                            input logic cs, input logic cw, input logic os, input logic ow,
                            input logic [3:0] cnt);
    chk({tag, ".res_s"}, {8'h0, res_s}, {8'h0, rs});
    chk({tag, ".res_w"}, {8'h0, res_w}, {8'h0, rw});
    chk({tag, ".vld_s"}, {15'h0, vld_s}, {15'h0, vld});
    chk({tag, ".vld_w"}, {15'h0, vld_w}, {15'h0, vld});
    chk({tag, ".cy_s"},  {15'h0, cy_s},  {15'h0, cs});
    chk({tag, ".cy_w"},  {15'h0, cy_w},  {15'h0, cw});
    chk({tag, ".ovf_s"}, {15'h0, ovf_s}, {15'h0, os});
    chk({tag, ".ovf_w"}, {15'h0, ovf_w}, {15'h0, ow});
    chk({tag, ".cnt_s"}, {12'h0, cnt_s}, {12'h0, cnt});
    chk({tag, ".cnt_w"}, {12'h0, cnt_w}, {12'h0, cnt});
  endtask

  // Present inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic en, input logic v, input logic [1:0] o,
                      input logic [7:0] aa, input logic [7:0] bb, input logic clr);
    ena = en; in_valid = v; op = o; a = aa; b = bb; acc_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, ADD, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; op = ADD; a = '0; b = '0; acc_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 8'd0, 8'd0, 0, 0, 0, 0, 0, 4'd0);
    rst_n = 1'b1;
    idle();
    expect_out("post_reset_idle", 8'd0, 8'd0, 0, 0, 0, 0, 0, 4'd0);

    // Overflowing ADD: clamp vs wrap, raw carry, sticky set.
    step(1, 1, ADD, 8'd200, 8'd100, 0);
    expect_out("add_ovf", 8'd255, 8'd44, 1, 1, 1, 1, 1, 4'd0);
    idle();
    expect_out("add_ovf_hold", 8'd255, 8'd44, 0, 1, 1, 1, 1, 4'd0);

    // Underflowing SUB, then a clean ADD keeps the sticky flag.
    step(1, 1, SUB, 8'd5, 8'd9, 0);
    expect_out("sub_unf", 8'd0, 8'd252, 1, 1, 1, 1, 1, 4'd0);
    step(1, 1, ADD, 8'd1, 8'd1, 0);
    expect_out("add_1_1", 8'd2, 8'd2, 1, 0, 0, 1, 1, 4'd0);

    // Load then accumulate back-to-back; DEC below zero.
    step(1, 1, ADD, 8'd10, 8'd20, 0);
    expect_out("add_10_20", 8'd30, 8'd30, 1, 0, 0, 1, 1, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, ACC, 8'd5, 8'd99, 0);
      expect_out($sformatf("acc5_%0d", i), 8'(30 + 5 * i), 8'(30 + 5 * i), 1, 0, 0, 1, 1, 4'(i));
    end
    step(1, 1, DEC, 8'd50, 8'd0, 0);
    expect_out("dec_50", 8'd0, 8'd251, 1, 1, 1, 1, 1, 4'd4);

    // 20 ACC a=1: count saturates at 15; wrap instance goes 251 -> 15.
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, ACC, 8'd1, 8'd0, 0);
      chk($sformatf("acc1_cnt_%0d", i), {12'h0, cnt_s}, (4 + i > 15) ? 16'd15 : 16'(4 + i));
      chk($sformatf("acc1_res_%0d", i), {8'h0, res_s}, 16'(i));
    end
    expect_out("acc1_end", 8'd20, 8'd15, 1, 0, 0, 1, 1, 4'd15);

    // acc_clr beats a simultaneous op.
    step(1, 1, ADD, 8'd7, 8'd7, 1);
    expect_out("clr_prio", 8'd0, 8'd0, 0, 0, 0, 0, 0, 4'd0);

    // Asynchronous reset mid-stream from result 0x55.
    step(1, 1, ADD, 8'h50, 8'h05, 0);
    expect_out("load_55", 8'h55, 8'h55, 1, 0, 0, 0, 0, 4'd0);
    step(1, 1, ACC, 8'd0, 8'd0, 0);
    expect_out("acc0_55", 8'h55, 8'h55, 1, 0, 0, 0, 0, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 8'd0, 8'd0, 0, 0, 0, 0, 0, 4'd0);
    step(1, 1, ADD, 8'd9, 8'd9, 0);
    expect_out("rst_held", 8'd0, 8'd0, 0, 0, 0, 0, 0, 4'd0);
    rst_n = 1'b1;
    idle();
    expect_out("rst_release_idle", 8'd0, 8'd0, 0, 0, 0, 0, 0, 4'd0);
    step(1, 1, ADD, 8'd3, 8'd4, 0);
    expect_out("first_after_rst", 8'd7, 8'd7, 1, 0, 0, 0, 0, 4'd0);

    // Build state with sticky and count set, then freeze it with ena low.
    step(1, 1, ADD, 8'd250, 8'd10, 0);
    expect_out("add_250_10", 8'd255, 8'd4, 1, 1, 1, 1, 1, 4'd0);
    step(1, 1, ACC, 8'd1, 8'd0, 0);
    expect_out("acc_sat", 8'd255, 8'd5, 1, 1, 0, 1, 1, 4'd1);
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, ADD, 8'd100, 8'd100, 1);
      expect_out($sformatf("ena_low_%0d", i), 8'd255, 8'd5, 0, 1, 0, 1, 1, 4'd1);
    end
    step(1, 1, ACC, 8'd3, 8'd0, 0);
    expect_out("ena_back_acc3", 8'd255, 8'd8, 1, 1, 0, 1, 1, 4'd2);
    idle();
    expect_out("final_idle", 8'd255, 8'd8, 0, 1, 0, 1, 1, 4'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
